// File: rtl/sha3_digest_out_buf.sv
// sha3_digest_out_buf: captures the truncated Keccak digest, presents it zero-padded in parallel
// and streams it as WORD_BITS words over a valid/ready handshake.
// Optional build macro SHA3_OUT_BYTESWAP_EN byte-reverses each streamed word for big-endian hosts.
module sha3_digest_out_buf #(
    parameter int DIGEST_BITS = 512,
    parameter int OUT_BITS    = 576,
    parameter int WORD_BITS   = 64
) (
    input  logic                 inClk,
    input  logic                 inRstN,
    input  logic                 inInit,
    input  logic                 inWr,
    input  logic [1599:0]        inData,
    input  logic                 inReady,
    output logic [OUT_BITS-1:0]  outData,
    output logic [WORD_BITS-1:0] outWord,
    output logic                 outValid,
    output logic                 outDone,
    output logic                 outOverrun
);
    localparam int NWORDS = (DIGEST_BITS + WORD_BITS - 1) / WORD_BITS;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PADW = NWORDS * WORD_BITS;
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state, nextState;
    logic [DIGEST_BITS-1:0] dig;
    logic [IW-1:0]          idx;
    logic [PADW-1:0]        digPad;
    logic [WORD_BITS-1:0]   laneWord;
    logic                   handshake;
    logic                   unusedBits;

    assign unusedBits = ^inData[1599:DIGEST_BITS];
    assign handshake  = (state == STREAM) && inReady;

    // State register; reset abandons any stream in flight
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) state <= IDLE;
        else         state <= nextState;
    end

    // Next state and handshake flags; init beats write, write beats a handshake
    always_comb begin
        nextState = state;
        outValid  = (state == STREAM);
        outDone   = (state == DONE);
        if (inInit)                      nextState = IDLE;
        else if (inWr)                   nextState = STREAM;
        else if (handshake && idx == LAST) nextState = DONE;
    end

    // Digest capture, word index and sticky overrun flag
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            dig        <= '0;
            idx        <= '0;
            outOverrun <= 1'b0;
        end else if (inInit) begin
            dig        <= '0;
            idx        <= '0;
            outOverrun <= 1'b0;
        end else if (inWr) begin
            dig <= inData[DIGEST_BITS-1:0];
            idx <= '0;
            if (state == STREAM) outOverrun <= 1'b1;
        end else if (handshake && idx != LAST) begin
            idx <= idx + IW'(1);
        end
    end

    // Zero-extend the digest for the parallel output and the word view
    always_comb begin
        outData                    = '0;
        outData[DIGEST_BITS-1:0]   = dig;
        digPad                     = '0;
        digPad[DIGEST_BITS-1:0]    = dig;
    end

    // Select the current stream word; partial last word reads zero above the digest
    always_comb begin
        laneWord = '0;
        for (int i = 0; i < NWORDS; i++)
            if (idx == IW'(i)) laneWord = digPad[i*WORD_BITS +: WORD_BITS];
    end

    // Present the word in lane order, or byte-reversed for big-endian hosts
    always_comb begin
        outWord = '0;
`ifdef SHA3_OUT_BYTESWAP_EN
        for (int b = 0; b < WORD_BITS / 8; b++)
            outWord[WORD_BITS-1-8*b -: 8] = laneWord[8*b +: 8];
`else
        outWord = laneWord;
`endif
    end
endmodule

// File: tb/tb_sha3_digest_out_buf.sv
// tb_sha3_digest_out_buf: table-driven check of capture, streaming, backpressure, overrun,
// init and asynchronous reset, plus a 224-bit instance for the partial last word.
module tb_sha3_digest_out_buf;
    logic          inClk = 1'b0, inRstN = 1'b0, inInit = 1'b0, inWr = 1'b0, inReady = 1'b0;
    logic [1599:0] inData = '0;
    logic [575:0]  outData, outData2;
    logic [63:0]   outWord, outWord2;
    logic          outValid, outDone, outOverrun, outValid2, outDone2, outOverrun2;
    int            checks = 0, failures = 0;

    sha3_digest_out_buf dut (
        .inClk(inClk), .inRstN(inRstN), .inInit(inInit), .inWr(inWr), .inData(inData),
        .inReady(inReady), .outData(outData), .outWord(outWord), .outValid(outValid),
        .outDone(outDone), .outOverrun(outOverrun)
    );

    sha3_digest_out_buf #(.DIGEST_BITS(224), .OUT_BITS(576), .WORD_BITS(64)) dut224 (
        .inClk(inClk), .inRstN(inRstN), .inInit(inInit), .inWr(inWr), .inData(inData),
        .inReady(inReady), .outData(outData2), .outWord(outWord2), .outValid(outValid2),
        .outDone(outDone2), .outOverrun(outOverrun2)
    );

    always #5 inClk = ~inClk;

    typedef struct {
        logic wr, init, rdy;
        logic [7:0] base;
        logic ev, ed, eo, hasDig;
        int eidx;
        logic [7:0] ebase;
    } vec_t;

    vec_t vecs[64];
    int nv = 0;

    function automatic logic [1599:0] mkData(logic [7:0] base);
        logic [1599:0] d = '1;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [575:0] digOf(logic [7:0] base);
        logic [575:0] d = '0;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = base + 8'(i);
        return d;
    endfunction

    function automatic logic [63:0] swapW(logic [63:0] w);
        logic [63:0] r = w;
`ifdef SHA3_OUT_BYTESWAP_EN
        for (int j = 0; j < 8; j++) r[63-8*j -: 8] = w[8*j +: 8];
`endif
        return r;
    endfunction

    function automatic logic [63:0] wordOf(logic [7:0] base, int k);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = base + 8'(8*k + j);
        return swapW(w);
    endfunction

    function automatic void add(logic wr, logic init, logic rdy, logic [7:0] base, logic ev,
                                logic ed, logic eo, logic hasDig, int eidx, logic [7:0] ebase);
        vecs[nv] = '{wr, init, rdy, base, ev, ed, eo, hasDig, eidx, ebase};
        nv++;
    endfunction

    task automatic chk(string name, logic [575:0] act, logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(logic wr, logic init, logic rdy, logic [1599:0] d);
        inWr = wr; inInit = init; inReady = rdy; inData = d;
        @(posedge inClk);
        #1;
    endtask

    initial begin
        // main sequence: A stream with ready high
        add(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        for (int k = 1; k < 8; k++) add(0, 0, 1, 8'h00, 1, 0, 0, 1, k, 8'h00);
        add(0, 0, 1, 8'h00, 0, 1, 0, 1, 7, 8'h00);
        add(0, 0, 0, 8'h00, 0, 1, 0, 1, 7, 8'h00);
        // backpressure 1,0,0 per word
        add(1, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            add(0, 0, 1, 8'h00, k < 7, k == 7, 0, 1, (k < 7) ? k + 1 : 7, 8'h00);
            add(0, 0, 0, 8'h00, k < 7, k == 7, 0, 1, (k < 7) ? k + 1 : 7, 8'h00);
            add(0, 0, 0, 8'h00, k < 7, k == 7, 0, 1, (k < 7) ? k + 1 : 7, 8'h00);
        end
        // overrun after three accepted words, then init clears
        add(1, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        for (int k = 1; k <= 3; k++) add(0, 0, 1, 8'h00, 1, 0, 0, 1, k, 8'h00);
        add(1, 0, 1, 8'h40, 1, 0, 1, 1, 0, 8'h40);
        add(0, 0, 1, 8'h00, 1, 0, 1, 1, 1, 8'h40);
        add(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 1, 1, 8'h40, 0, 0, 0, 0, 0, 8'h00);

        // reset state
        #12;
        chk("rst_data", outData, '0);
        chk("rst_word", {512'b0, outWord}, '0);
        chk("rst_flags", {573'b0, outValid, outDone, outOverrun}, '0);
        @(negedge inClk);
        inRstN = 1'b1;
        @(posedge inClk);
        #1;

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].wr, vecs[i].init, vecs[i].rdy, mkData(vecs[i].base));
            chk($sformatf("v%0d_valid", i), {575'b0, outValid}, {575'b0, vecs[i].ev});
            chk($sformatf("v%0d_done", i), {575'b0, outDone}, {575'b0, vecs[i].ed});
            chk($sformatf("v%0d_ovr", i), {575'b0, outOverrun}, {575'b0, vecs[i].eo});
            chk($sformatf("v%0d_data", i), outData, vecs[i].hasDig ? digOf(vecs[i].ebase) : '0);
            if (!vecs[i].hasDig)
                chk($sformatf("v%0d_word0", i), {512'b0, outWord}, '0);
            else if (vecs[i].ev)
                chk($sformatf("v%0d_word", i), {512'b0, outWord}, {512'b0, wordOf(vecs[i].ebase, vecs[i].eidx)});
        end

        // 224-bit digest: partial last word zero-padded
        step(1, 0, 0, '1);
        chk("d224_data", outData2, {352'b0, {224{1'b1}}});
        chk("d224_valid", {575'b0, outValid2}, 576'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d224_word%0d", k), {512'b0, outWord2},
                {512'b0, (k < 3) ? 64'hFFFFFFFFFFFFFFFF : swapW(64'h00000000FFFFFFFF)});
            step(0, 0, 1, '0);
        end
        chk("d224_done", {574'b0, outValid2, outDone2}, 576'd1);
        step(0, 1, 0, '0);

        // asynchronous reset while word 5 is presented
        step(1, 0, 1, mkData(8'h00));
        for (int k = 0; k < 5; k++) step(0, 0, 1, '0);
        chk("mid_word5", {512'b0, outWord}, {512'b0, wordOf(8'h00, 5)});
        inReady = 1'b0;
        #3 inRstN = 1'b0;
        #1;
        chk("arst_data", outData, '0);
        chk("arst_word", {512'b0, outWord}, '0);
        chk("arst_flags", {573'b0, outValid, outDone, outOverrun}, '0);
        #2 inRstN = 1'b1;
        @(posedge inClk);
        #1;
        chk("arst_idle", {574'b0, outValid, outDone}, '0);
        step(1, 0, 0, mkData(8'h40));
        chk("arst_restart_word", {512'b0, outWord}, {512'b0, wordOf(8'h40, 0)});
        chk("arst_restart_valid", {575'b0, outValid}, 576'd1);
        step(0, 0, 0, '0);
        chk("arst_hold_word", {512'b0, outWord}, {512'b0, wordOf(8'h40, 0)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
